// File: rtl/divisor_frequencia_prog.sv
// Programmable clock divider: period and high-phase length are loaded through a
// valid/ready handshake and take effect only on a period boundary.
module divisor_frequencia_prog #(
    parameter int     WIDTH           = 28,
    parameter longint DEFAULT_DIVISOR = 50000000,
    parameter longint DEFAULT_HIGH    = DEFAULT_DIVISOR / 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_divisor,
    input  logic [WIDTH-1:0] load_high,
    output logic             load_ready,
    output logic             load_err,
    output logic             clock_out,
    output logic             tick,
    output logic             pending
);

    if (DEFAULT_DIVISOR < 2 || DEFAULT_DIVISOR >= (longint'(1) << WIDTH)) begin : g_bad_default
        $error("DEFAULT_DIVISOR must lie in [2, 2**WIDTH - 1]");
    end

    localparam longint          HIGH_CLAMPED = (DEFAULT_HIGH < DEFAULT_DIVISOR) ? DEFAULT_HIGH
                                                                                : DEFAULT_DIVISOR;
    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIVISOR);
    localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(HIGH_CLAMPED);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] active_high;
    logic [WIDTH-1:0] shadow_div;
    logic [WIDTH-1:0] shadow_high;

    logic             last;
    logic             accept;
    logic             apply;

    assign last       = (counter == active_div - ONE);
    assign accept     = load_valid && !pending;
    // A pending pair never coexists with an accept, so a request taken on a
    // wrap edge naturally waits for the following wrap.
    assign apply      = pending && (!enable || last);

    assign load_ready = !pending;
    assign tick       = enable && last;
    // active_high is clamped to active_div, so this subtraction cannot wrap.
    assign clock_out  = enable && (counter >= active_div - active_high);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, whatever order the lines appear in.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            counter     <= '0;
            active_div  <= RST_DIV;
            active_high <= RST_HIGH;
            shadow_div  <= RST_DIV;
            shadow_high <= RST_HIGH;
            pending     <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            load_err <= 1'b0;

            if (!enable || last) begin
                counter <= '0;
            end else begin
                counter <= counter + ONE;
            end

            if (apply) begin
                active_div  <= shadow_div;
                active_high <= shadow_high;
                pending     <= 1'b0;
            end

            if (accept) begin
                if (load_divisor >= TWO) begin
                    shadow_div  <= load_divisor;
                    shadow_high <= (load_high > load_divisor) ? load_divisor : load_high;
                    pending     <= 1'b1;
                end else begin
                    load_err <= 1'b1;
                end
            end
        end
    end

endmodule
